// File: rtl/ee354_2048_move_ctrl_if.sv
// Handshake between the 2048 move controller and the board engine:
// move start/done, board status flags, board clear and tile spawn.
interface ee354_2048_move_ctrl_if;
  logic        eng_start;
  logic [1:0]  eng_dir;
  logic        eng_done;
  logic        eng_changed;
  logic [15:0] empty_mask;
  logic        has_2048;
  logic        can_merge;
  logic        clr_board;
  logic        spawn_req;
  logic [3:0]  spawn_idx;
  logic        spawn_ack;

  modport master (
    output eng_start, eng_dir, clr_board, spawn_req, spawn_idx,
    input  eng_done, eng_changed, empty_mask, has_2048, can_merge, spawn_ack
  );

  modport slave (
    input  eng_start, eng_dir, clr_board, spawn_req, spawn_idx,
    output eng_done, eng_changed, empty_mask, has_2048, can_merge, spawn_ack
  );
endinterface

// File: rtl/ee354_2048_move_ctrl.sv
// 2048 game move controller: button edge detect, move sequencing through the
// board engine, pseudo-random tile spawn, win/lose detection and move counter.
module ee354_2048_move_ctrl (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   up,
  input  logic                   down,
  input  logic                   left,
  input  logic                   right,
  input  logic                   restart,
  ee354_2048_move_ctrl_if.master eng,
  output logic                   q_I,
  output logic                   q_Idle,
  output logic                   q_Move,
  output logic                   q_Spawn,
  output logic                   q_Check,
  output logic                   q_Win,
  output logic                   q_Lose,
  output logic [15:0]            move_count
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_MOVE,
    S_SPAWN,
    S_CHECK,
    S_WIN,
    S_LOSE
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  btn_q;
  logic [3:0]  btn_now;
  logic [3:0]  press;
  logic [1:0]  press_dir;
  logic [1:0]  dir_q, dir_d;
  logic        start_q, start_d;
  logic        spawn_req_q, spawn_req_d;
  logic [3:0]  spawn_idx_q, spawn_idx_d;
  logic [3:0]  first_empty;
  logic [3:0]  cand;
  logic        found;
  logic [15:0] count_q, count_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        board_full;

  assign btn_now    = {up, down, left, right};
  assign press      = btn_now & ~btn_q;
  assign board_full = (eng.empty_mask == '0);
  assign lfsr_d     = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  always_comb begin
    if (press[3])      press_dir = 2'b00;
    else if (press[2]) press_dir = 2'b01;
    else if (press[1]) press_dir = 2'b10;
    else               press_dir = 2'b11;
  end

  // First empty cell at or after lfsr[3:0], wrapping 15 -> 0.
  always_comb begin
    first_empty = lfsr_q[3:0];
    found       = 1'b0;
    cand        = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      cand = lfsr_q[3:0] + 4'(i);
      if (!found && eng.empty_mask[cand]) begin
        found       = 1'b1;
        first_empty = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    start_d     = 1'b0;
    spawn_req_d = spawn_req_q;
    spawn_idx_d = spawn_idx_q;
    count_d     = count_q;
    unique case (state_q)
      S_INIT: begin
        count_d     = '0;
        spawn_req_d = 1'b0;
        state_d     = S_SPAWN;
      end
      S_IDLE: begin
        if (restart) begin
          state_d = S_INIT;
        end else if (|press) begin
          state_d = S_MOVE;
          start_d = 1'b1;
          dir_d   = press_dir;
        end
      end
      S_MOVE: begin
        if (eng.eng_done) begin
          if (eng.eng_changed) begin
            count_d = (count_q == '1) ? count_q : count_q + 16'd1;
            state_d = S_SPAWN;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_SPAWN: begin
        // spawn_req still low inside SPAWN marks the entry cycle.
        if (!spawn_req_q) begin
          if (board_full) begin
            state_d = S_CHECK;
          end else begin
            spawn_idx_d = first_empty;
            spawn_req_d = 1'b1;
          end
        end else if (eng.spawn_ack) begin
          spawn_req_d = 1'b0;
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        if (eng.has_2048)                      state_d = S_WIN;
        else if (board_full && !eng.can_merge) state_d = S_LOSE;
        else                                   state_d = S_IDLE;
      end
      S_WIN, S_LOSE: begin
        if (restart) state_d = S_INIT;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_INIT;
      btn_q       <= '0;
      dir_q       <= 2'b00;
      start_q     <= 1'b0;
      spawn_req_q <= 1'b0;
      spawn_idx_q <= '0;
      count_q     <= '0;
      lfsr_q      <= 16'hACE1;
    end else begin
      state_q     <= state_d;
      btn_q       <= btn_now;
      dir_q       <= dir_d;
      start_q     <= start_d;
      spawn_req_q <= spawn_req_d;
      spawn_idx_q <= spawn_idx_d;
      count_q     <= count_d;
      lfsr_q      <= lfsr_d;
    end
  end

  assign eng.eng_start = start_q;
  assign eng.eng_dir   = dir_q;
  assign eng.clr_board = (state_q == S_INIT);
  assign eng.spawn_req = spawn_req_q;
  assign eng.spawn_idx = spawn_idx_q;

  assign q_I     = (state_q == S_INIT);
  assign q_Idle  = (state_q == S_IDLE);
  assign q_Move  = (state_q == S_MOVE);
  assign q_Spawn = (state_q == S_SPAWN);
  assign q_Check = (state_q == S_CHECK);
  assign q_Win   = (state_q == S_WIN);
  assign q_Lose  = (state_q == S_LOSE);

  assign move_count = count_q;

endmodule

// File: tb/tb_ee354_2048_move_ctrl.sv
// Self-checking bench for ee354_2048_move_ctrl: directed scenarios plus
// randomized moves checked against a transaction-level game model.
module tb_ee354_2048_move_ctrl;

  localparam logic [6:0] Q_I     = 7'b1000000;
  localparam logic [6:0] Q_IDLE  = 7'b0100000;
  localparam logic [6:0] Q_MOVE  = 7'b0010000;
  localparam logic [6:0] Q_SPAWN = 7'b0001000;
  localparam logic [6:0] Q_CHECK = 7'b0000100;
  localparam logic [6:0] Q_WIN   = 7'b0000010;
  localparam logic [6:0] Q_LOSE  = 7'b0000001;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, restart = 1'b0;
  logic        q_I, q_Idle, q_Move, q_Spawn, q_Check, q_Win, q_Lose;
  logic [15:0] move_count;
  logic [6:0]  qv;
  logic [15:0] m_lfsr;
  logic [15:0] exp_count = '0;
  int          total = 0;
  int          bad = 0;

  ee354_2048_move_ctrl_if eif();

  ee354_2048_move_ctrl dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .up        (up),
    .down      (down),
    .left      (left),
    .right     (right),
    .restart   (restart),
    .eng       (eif),
    .q_I       (q_I),
    .q_Idle    (q_Idle),
    .q_Move    (q_Move),
    .q_Spawn   (q_Spawn),
    .q_Check   (q_Check),
    .q_Win     (q_Win),
    .q_Lose    (q_Lose),
    .move_count(move_count)
  );

  always #5 Clk = ~Clk;

  assign qv = {q_I, q_Idle, q_Move, q_Spawn, q_Check, q_Win, q_Lose};

  // Fibonacci LFSR, taps 16,14,13,11 counted from the output end.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = s[16-16] ^ s[16-14] ^ s[16-13] ^ s[16-11];
    return {fb, s[15:1]};
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) m_lfsr <= 16'hACE1;
    else          m_lfsr <= lfsr_next(m_lfsr);
  end

  function automatic logic [3:0] first_empty(input logic [15:0] mask, input logic [3:0] start);
    int c;
    for (int k = 0; k < 16; k++) begin
      c = (int'(start) + k) % 16;
      if (mask[c]) return 4'(c);
    end
    return 4'd0;
  endfunction

  function automatic logic [1:0] prio_dir(input logic [3:0] b);
    if (b[3]) return 2'b00;
    if (b[2]) return 2'b01;
    if (b[1]) return 2'b10;
    return 2'b11;
  endfunction

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic set_btn(input logic [3:0] b);
    {up, down, left, right} = b;
  endtask

  task automatic start_move(input logic [3:0] b);
    set_btn(4'b0000);
    tick();
    set_btn(b);
    tick();
  endtask

  task automatic run_to_idle(output bit ok);
    ok = 1'b0;
    eif.empty_mask = 16'hFFFF;
    eif.has_2048   = 1'b0;
    eif.can_merge  = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (qv === Q_IDLE) begin
        ok = 1'b1;
        break;
      end
      eif.spawn_ack = eif.spawn_req;
      tick();
    end
    eif.spawn_ack = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b1;
    #3 Reset_n = 1'b0;
    repeat (2) tick();
    total++; if (qv !== Q_I) begin bad++; $display("FAIL reset_state got=%b exp=%b", qv, Q_I); end
    total++; if ({eif.clr_board, eif.eng_start, eif.spawn_req} !== 3'b100) begin bad++; $display("FAIL reset_ctl got=%b exp=100", {eif.clr_board, eif.eng_start, eif.spawn_req}); end
    total++; if ({eif.spawn_idx, eif.eng_dir} !== 6'd0) begin bad++; $display("FAIL reset_idx_dir got=%h exp=0", {eif.spawn_idx, eif.eng_dir}); end
    total++; if (move_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", move_count); end
  endtask

  task automatic test_init_spawn();
    logic [3:0] exp_idx;
    eif.empty_mask = 16'hFFFF;
    Reset_n = 1'b1;
    #1;
    total++; if ({qv, eif.clr_board} !== {Q_I, 1'b1}) begin bad++; $display("FAIL init_cycle got=%b exp=%b", {qv, eif.clr_board}, {Q_I, 1'b1}); end
    tick();
    total++; if ({qv, eif.spawn_req, eif.clr_board} !== {Q_SPAWN, 2'b00}) begin bad++; $display("FAIL init_to_spawn got=%b exp=%b", {qv, eif.spawn_req, eif.clr_board}, {Q_SPAWN, 2'b00}); end
    exp_idx = first_empty(eif.empty_mask, m_lfsr[3:0]);
    tick();
    total++; if ({eif.spawn_req, eif.spawn_idx} !== {1'b1, exp_idx}) begin bad++; $display("FAIL init_spawn_idx got=%b/%0d exp=1/%0d", eif.spawn_req, eif.spawn_idx, exp_idx); end
    tick();
    total++; if ({qv, eif.spawn_req} !== {Q_SPAWN, 1'b1}) begin bad++; $display("FAIL init_spawn_hold got=%b exp=%b", {qv, eif.spawn_req}, {Q_SPAWN, 1'b1}); end
    eif.spawn_ack = 1'b1;
    tick();
    eif.spawn_ack = 1'b0;
    total++; if ({qv, eif.spawn_req} !== {Q_CHECK, 1'b0}) begin bad++; $display("FAIL init_check got=%b exp=%b", {qv, eif.spawn_req}, {Q_CHECK, 1'b0}); end
    tick();
    total++; if ({qv, move_count} !== {Q_IDLE, 16'd0}) begin bad++; $display("FAIL init_idle got=%b/%0d exp=%b/0", qv, move_count, Q_IDLE); end
  endtask

  task automatic test_priority_hold();
    int starts;
    int reqs;
    bit ok;
    start_move(4'b1001);
    total++; if ({qv, eif.eng_start, eif.eng_dir} !== {Q_MOVE, 1'b1, 2'b00}) begin bad++; $display("FAIL prio_up_right got=%b exp=%b", {qv, eif.eng_start, eif.eng_dir}, {Q_MOVE, 3'b100}); end
    starts = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (eif.eng_start) starts++;
    end
    total++; if (starts !== 0) begin bad++; $display("FAIL hold_no_repeat got=%0d exp=0", starts); end
    eif.eng_done = 1'b1; eif.eng_changed = 1'b0;
    tick();
    eif.eng_done = 1'b0;
    total++; if ({qv, move_count} !== {Q_IDLE, exp_count}) begin bad++; $display("FAIL unchanged_idle got=%b/%0d exp=%b/%0d", qv, move_count, Q_IDLE, exp_count); end
    reqs = 0;
    for (int i = 0; i < 5; i++) begin
      if (eif.spawn_req) reqs++;
      tick();
    end
    total++; if ({qv, 4'(reqs)} !== {Q_IDLE, 4'd0}) begin bad++; $display("FAIL unchanged_no_spawn got=%b/%0d exp=%b/0", qv, reqs, Q_IDLE); end
    start_move(4'b0100);
    total++; if ({qv, eif.eng_dir} !== {Q_MOVE, 2'b01}) begin bad++; $display("FAIL down_move got=%b exp=%b", {qv, eif.eng_dir}, {Q_MOVE, 2'b01}); end
    eif.eng_done = 1'b1; eif.eng_changed = 1'b1;
    tick();
    eif.eng_done = 1'b0;
    exp_count++;
    total++; if ({qv, move_count} !== {Q_SPAWN, exp_count}) begin bad++; $display("FAIL changed_count got=%b/%0d exp=%b/%0d", qv, move_count, Q_SPAWN, exp_count); end
    run_to_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL changed_to_idle got=%b exp=%b", qv, Q_IDLE); end
  endtask

  task automatic test_spawn_wrap();
    logic [15:0] wmask [2];
    logic [3:0]  wnib  [2];
    logic [3:0]  widx  [2];
    logic [15:0] nxt;
    bit          found;
    wmask[0] = 16'h8000; wnib[0] = 4'h3; widx[0] = 4'd15;
    wmask[1] = 16'h0001; wnib[1] = 4'hF; widx[1] = 4'd0;
    for (int t = 0; t < 2; t++) begin
      start_move(4'b0010);
      eif.empty_mask = wmask[t];
      found = 1'b0;
      for (int i = 0; i < 400; i++) begin
        nxt = lfsr_next(m_lfsr);
        if (nxt[3:0] == wnib[t]) begin
          found = 1'b1;
          break;
        end
        tick();
      end
      total++; if (!found) begin bad++; $display("FAIL wrap_lfsr_wait got=timeout exp=nibble_%h", wnib[t]); end
      total++; if (qv !== Q_MOVE) begin bad++; $display("FAIL wrap_in_move got=%b exp=%b", qv, Q_MOVE); end
      eif.eng_done = 1'b1; eif.eng_changed = 1'b1;
      tick();
      eif.eng_done = 1'b0;
      exp_count++;
      tick();
      total++; if ({qv, eif.spawn_req, eif.spawn_idx} !== {Q_SPAWN, 1'b1, widx[t]}) begin bad++; $display("FAIL wrap_idx_%0d got=%b/%0d exp=%b/%0d", t, qv, eif.spawn_idx, Q_SPAWN, widx[t]); end
      eif.spawn_ack = 1'b1;
      tick();
      eif.spawn_ack = 1'b0;
      tick();
      total++; if ({qv, move_count} !== {Q_IDLE, exp_count}) begin bad++; $display("FAIL wrap_idle_%0d got=%b/%0d exp=%b/%0d", t, qv, move_count, Q_IDLE, exp_count); end
    end
  endtask

  task automatic test_restart();
    bit ok;
    start_move(4'b1000);
    restart = 1'b1;
    repeat (3) tick();
    total++; if (qv !== Q_MOVE) begin bad++; $display("FAIL restart_in_move got=%b exp=%b", qv, Q_MOVE); end
    eif.empty_mask = 16'hFFFF; eif.has_2048 = 1'b0; eif.can_merge = 1'b1;
    eif.eng_done = 1'b1; eif.eng_changed = 1'b1;
    tick();
    eif.eng_done = 1'b0;
    exp_count++;
    total++; if ({qv, move_count} !== {Q_SPAWN, exp_count}) begin bad++; $display("FAIL restart_move_done got=%b/%0d exp=%b/%0d", qv, move_count, Q_SPAWN, exp_count); end
    tick();
    eif.spawn_ack = 1'b1;
    tick();
    eif.spawn_ack = 1'b0;
    total++; if (qv !== Q_CHECK) begin bad++; $display("FAIL restart_in_check got=%b exp=%b", qv, Q_CHECK); end
    tick();
    total++; if (qv !== Q_IDLE) begin bad++; $display("FAIL restart_check_idle got=%b exp=%b", qv, Q_IDLE); end
    tick();
    restart = 1'b0;
    total++; if ({qv, eif.clr_board} !== {Q_I, 1'b1}) begin bad++; $display("FAIL restart_idle_init got=%b exp=%b", {qv, eif.clr_board}, {Q_I, 1'b1}); end
    exp_count = '0;
    run_to_idle(ok);
    total++; if ({ok, move_count} !== {1'b1, exp_count}) begin bad++; $display("FAIL restart_cleared got=%b/%0d exp=1/0", ok, move_count); end
  endtask

  task automatic test_win_lose();
    bit ok;
    start_move(4'b1000);
    eif.empty_mask = 16'h0000; eif.has_2048 = 1'b1; eif.can_merge = 1'b0;
    eif.eng_done = 1'b1; eif.eng_changed = 1'b1;
    tick();
    eif.eng_done = 1'b0;
    total++; if (qv !== Q_SPAWN) begin bad++; $display("FAIL win_spawn got=%b exp=%b", qv, Q_SPAWN); end
    tick();
    total++; if ({qv, eif.spawn_req} !== {Q_CHECK, 1'b0}) begin bad++; $display("FAIL full_no_spawn got=%b exp=%b", {qv, eif.spawn_req}, {Q_CHECK, 1'b0}); end
    tick();
    total++; if (qv !== Q_WIN) begin bad++; $display("FAIL win_precedence got=%b exp=%b", qv, Q_WIN); end
    start_move(4'b0001);
    total++; if ({qv, eif.eng_start} !== {Q_WIN, 1'b0}) begin bad++; $display("FAIL win_ignores_btn got=%b exp=%b", {qv, eif.eng_start}, {Q_WIN, 1'b0}); end
    restart = 1'b1;
    eif.empty_mask = 16'hFFFF; eif.has_2048 = 1'b0; eif.can_merge = 1'b1;
    tick();
    restart = 1'b0;
    total++; if (qv !== Q_I) begin bad++; $display("FAIL win_restart got=%b exp=%b", qv, Q_I); end
    exp_count = '0;
    run_to_idle(ok);
    total++; if ({ok, move_count} !== {1'b1, exp_count}) begin bad++; $display("FAIL win_restart_idle got=%b/%0d exp=1/0", ok, move_count); end
    start_move(4'b0100);
    eif.empty_mask = 16'h0000; eif.has_2048 = 1'b0; eif.can_merge = 1'b0;
    eif.eng_done = 1'b1; eif.eng_changed = 1'b1;
    tick();
    eif.eng_done = 1'b0;
    repeat (2) tick();
    total++; if (qv !== Q_LOSE) begin bad++; $display("FAIL lose_state got=%b exp=%b", qv, Q_LOSE); end
    restart = 1'b1;
    eif.empty_mask = 16'hFFFF; eif.can_merge = 1'b1;
    tick();
    restart = 1'b0;
    total++; if (qv !== Q_I) begin bad++; $display("FAIL lose_restart got=%b exp=%b", qv, Q_I); end
    run_to_idle(ok);
    total++; if ({ok, move_count} !== {1'b1, exp_count}) begin bad++; $display("FAIL lose_restart_idle got=%b/%0d exp=1/0", ok, move_count); end
  endtask

  task automatic test_random();
    logic [3:0]  b;
    logic [1:0]  exp_dir;
    logic [15:0] mask;
    logic [3:0]  exp_idx;
    logic        chg;
    int          w;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        eif.eng_done = 1'b1; eif.eng_changed = 1'b1;
        tick();
        eif.eng_done = 1'b0;
        total++; if ({qv, move_count} !== {Q_IDLE, exp_count}) begin bad++; $display("FAIL rnd_idle_done got=%b/%0d exp=%b/%0d", qv, move_count, Q_IDLE, exp_count); end
      end
      b = 4'($urandom_range(1, 15));
      exp_dir = prio_dir(b);
      start_move(b);
      total++; if ({qv, eif.eng_start, eif.eng_dir} !== {Q_MOVE, 1'b1, exp_dir}) begin bad++; $display("FAIL rnd_start it=%0d got=%b exp=%b", it, {qv, eif.eng_start, eif.eng_dir}, {Q_MOVE, 1'b1, exp_dir}); end
      w = $urandom_range(0, 4);
      for (int i = 0; i < w; i++) begin
        set_btn(4'($urandom));
        tick();
        total++; if ({qv, eif.eng_start, eif.eng_dir} !== {Q_MOVE, 1'b0, exp_dir}) begin bad++; $display("FAIL rnd_move_hold it=%0d got=%b exp=%b", it, {qv, eif.eng_start, eif.eng_dir}, {Q_MOVE, 1'b0, exp_dir}); end
      end
      chg  = 1'($urandom_range(0, 1));
      mask = ($urandom_range(0, 3) == 0) ? 16'h0000 : (16'($urandom) & 16'($urandom));
      eif.empty_mask = mask; eif.has_2048 = 1'b0; eif.can_merge = 1'b1;
      eif.eng_done = 1'b1; eif.eng_changed = chg;
      tick();
      eif.eng_done = 1'b0;
      if (chg) begin
        if (exp_count != 16'hFFFF) exp_count++;
        total++; if ({qv, move_count} !== {Q_SPAWN, exp_count}) begin bad++; $display("FAIL rnd_spawn_entry it=%0d got=%b/%0d exp=%b/%0d", it, qv, move_count, Q_SPAWN, exp_count); end
        exp_idx = first_empty(mask, m_lfsr[3:0]);
        tick();
        if (mask == 16'h0000) begin
          total++; if ({qv, eif.spawn_req} !== {Q_CHECK, 1'b0}) begin bad++; $display("FAIL rnd_full it=%0d got=%b exp=%b", it, {qv, eif.spawn_req}, {Q_CHECK, 1'b0}); end
        end else begin
          w = $urandom_range(0, 3);
          for (int i = 0; i <= w; i++) begin
            total++; if ({qv, eif.spawn_req, eif.spawn_idx} !== {Q_SPAWN, 1'b1, exp_idx}) begin bad++; $display("FAIL rnd_spawn it=%0d got=%b/%0d exp=%b/%0d", it, qv, eif.spawn_idx, Q_SPAWN, exp_idx); end
            if (i < w) tick();
          end
          eif.spawn_ack = 1'b1;
          tick();
          eif.spawn_ack = 1'b0;
          total++; if ({qv, eif.spawn_req} !== {Q_CHECK, 1'b0}) begin bad++; $display("FAIL rnd_ack it=%0d got=%b exp=%b", it, {qv, eif.spawn_req}, {Q_CHECK, 1'b0}); end
        end
        tick();
      end
      total++; if ({qv, move_count} !== {Q_IDLE, exp_count}) begin bad++; $display("FAIL rnd_end it=%0d got=%b/%0d exp=%b/%0d", it, qv, move_count, Q_IDLE, exp_count); end
    end
  endtask

  task automatic test_reset_mid_move();
    int  starts;
    bit  ok;
    start_move(4'b0001);
    total++; if ({qv, eif.eng_dir} !== {Q_MOVE, 2'b11}) begin bad++; $display("FAIL mid_move_dir got=%b exp=%b", {qv, eif.eng_dir}, {Q_MOVE, 2'b11}); end
    #2 Reset_n = 1'b0;
    #1;
    total++; if ({qv, eif.eng_start, eif.spawn_req, eif.clr_board} !== {Q_I, 3'b001}) begin bad++; $display("FAIL mid_move_reset got=%b exp=%b", {qv, eif.eng_start, eif.spawn_req, eif.clr_board}, {Q_I, 3'b001}); end
    total++; if ({move_count, eif.eng_dir, eif.spawn_idx} !== 22'd0) begin bad++; $display("FAIL mid_move_reset_regs got=%h exp=0", {move_count, eif.eng_dir, eif.spawn_idx}); end
    tick();
    Reset_n = 1'b1;
    exp_count = '0;
    eif.eng_done = 1'b1; eif.eng_changed = 1'b1;
    starts = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (eif.eng_start) starts++;
    end
    eif.eng_done = 1'b0;
    total++; if ({4'(starts), move_count} !== {4'd0, exp_count}) begin bad++; $display("FAIL after_reset_done starts=%0d count=%0d exp=0/0", starts, move_count); end
    run_to_idle(ok);
    total++; if ({ok, move_count} !== {1'b1, 16'd0}) begin bad++; $display("FAIL after_reset_idle got=%b/%0d exp=1/0", ok, move_count); end
  endtask

  initial begin
    eif.eng_done    = 1'b0;
    eif.eng_changed = 1'b0;
    eif.empty_mask  = 16'hFFFF;
    eif.has_2048    = 1'b0;
    eif.can_merge   = 1'b1;
    eif.spawn_ack   = 1'b0;
    test_reset();
    test_init_spawn();
    test_priority_hold();
    test_spawn_wrap();
    test_restart();
    test_win_lose();
    test_random();
    test_reset_mid_move();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
